// File: rtl/stripes_ser_pkg.sv
// rtl/stripes_ser_pkg.sv - shared types and column-search helpers for the Stripes weight serializer
package stripes_ser_pkg;

  localparam int COL_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } ser_state_t;

  // Lowest set bit index; an empty mask maps to column 0 so it is still issued.
  function automatic logic [COL_IDX_W-1:0] lowest_set(input logic [7:0] m);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = COL_IDX_W'(i);
    end
  endfunction

  function automatic logic [COL_IDX_W-1:0] highest_set(input logic [7:0] m);
    highest_set = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) highest_set = COL_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/stripes_weight_serializer_if.sv
// rtl/stripes_weight_serializer_if.sv - weight handshake and MAC drive bundle
interface stripes_weight_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
);

  logic                                  w_valid;
  logic                                  w_ready;
  logic [DATA_WIDTH-1:0]                 w_data [VEC_LENGTH];
  logic                                  mac_en;
  logic                                  mac_load_accum;
  logic                                  mac_w_bit [VEC_LENGTH];
  logic [stripes_ser_pkg::COL_IDX_W-1:0] mac_column_idx;
  logic                                  mac_is_msb;
  logic                                  result_valid;
  logic                                  busy;

  modport master (
    output w_valid, w_data,
    input  w_ready, mac_en, mac_load_accum, mac_w_bit, mac_column_idx,
           mac_is_msb, result_valid, busy
  );

  modport slave (
    input  w_valid, w_data,
    output w_ready, mac_en, mac_load_accum, mac_w_bit, mac_column_idx,
           mac_is_msb, result_valid, busy
  );

endinterface

// File: rtl/stripes_col_mask.sv
// rtl/stripes_col_mask.sv - column OR mask and next-nonzero-column search
// Only instantiated when STRIPES_SER_SKIP_ZERO_EN is defined.
module stripes_col_mask
  import stripes_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic [DATA_WIDTH-1:0] w_data [VEC_LENGTH],
  input  logic [DATA_WIDTH-1:0] mask_q,
  input  logic [COL_IDX_W-1:0]  cur_col,
  output logic [DATA_WIDTH-1:0] mask_in,
  output logic [COL_IDX_W-1:0]  first_col,
  output logic [COL_IDX_W-1:0]  next_col,
  output logic                  is_last
);

  logic [7:0] in8;
  logic [7:0] q8;
  logic [7:0] below;

  always_comb begin
    mask_in = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      mask_in = mask_in | w_data[j];
    end
    in8   = '0;
    q8    = '0;
    below = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      in8[i] = mask_in[i];
      q8[i]  = mask_q[i];
    end
    // Candidates for the next column are the nonzero ones strictly below the current one.
    for (int i = 0; i < 8; i++) begin
      below[i] = q8[i] && (i < int'(cur_col));
    end
    first_col = highest_set(in8);
    next_col  = highest_set(below);
    is_last   = (cur_col == lowest_set(q8));
  end

endmodule

// File: rtl/stripes_weight_serializer.sv
// rtl/stripes_weight_serializer.sv - issues weight vectors to the Stripes MAC one bit-column per cycle
// Define STRIPES_SER_SKIP_ZERO_EN to skip columns that are zero across the whole vector.
module stripes_weight_serializer
  import stripes_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input logic clk,
  input logic reset,
  stripes_weight_serializer_if.slave bus
);

  ser_state_t            state;
  logic [COL_IDX_W-1:0]  col;
  logic [DATA_WIDTH-1:0] weights [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] w_in [VEC_LENGTH];
  logic                  first_col_q;
  logic                  load_q;
  logic [1:0]            vld_sr;
  logic [COL_IDX_W-1:0]  start_col;
  logic [COL_IDX_W-1:0]  next_col;
  logic                  last_col;
  logic                  handshake;

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_in[j] = bus.w_data[j];
    end
  end

`ifdef STRIPES_SER_SKIP_ZERO_EN
  logic [DATA_WIDTH-1:0] mask_in;
  logic [DATA_WIDTH-1:0] mask_q;

  stripes_col_mask #(
    .DATA_WIDTH(DATA_WIDTH),
    .VEC_LENGTH(VEC_LENGTH)
  ) u_col_mask (
    .w_data   (w_in),
    .mask_q   (mask_q),
    .cur_col  (col),
    .mask_in  (mask_in),
    .first_col(start_col),
    .next_col (next_col),
    .is_last  (last_col)
  );
`else
  assign start_col = COL_IDX_W'(DATA_WIDTH - 1);
  assign next_col  = col - COL_IDX_W'(1);
  assign last_col  = (col == '0);
`endif

  // Gated by reset so every output reads 0 while reset is held.
  assign bus.w_ready = reset && ((state != ISSUE) || last_col);
  assign handshake   = bus.w_valid && bus.w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      col         <= '0;
      first_col_q <= 1'b0;
      load_q      <= 1'b0;
      vld_sr      <= '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        weights[j] <= '0;
      end
`ifdef STRIPES_SER_SKIP_ZERO_EN
      mask_q      <= '0;
`endif
    end else begin
      // load_accum trails the first column by one cycle to cover the MAC psum_reg stage.
      load_q <= (state == ISSUE) && first_col_q;
      vld_sr <= {vld_sr[0], (state == ISSUE) && last_col};
      if (state == ISSUE) first_col_q <= 1'b0;
      if (handshake) begin
        state       <= ISSUE;
        col         <= start_col;
        first_col_q <= 1'b1;
        for (int j = 0; j < VEC_LENGTH; j++) begin
          weights[j] <= w_in[j];
        end
`ifdef STRIPES_SER_SKIP_ZERO_EN
        mask_q      <= mask_in;
`endif
      end else if (state == ISSUE) begin
        if (last_col) state <= DRAIN;
        else          col   <= next_col;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.mac_en         = (state != IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.mac_load_accum = load_q;
  assign bus.result_valid   = vld_sr[1];
  assign bus.mac_column_idx = (state == ISSUE) ? col : '0;
  assign bus.mac_is_msb     = (state == ISSUE) && (col == COL_IDX_W'(DATA_WIDTH - 1));

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      bus.mac_w_bit[j] = (state == ISSUE) && weights[j][col];
    end
  end

endmodule

// File: tb/tb_stripes_weight_serializer.sv
// tb/tb_stripes_weight_serializer.sv - self-checking bench for stripes_weight_serializer
module tb_stripes_weight_serializer;

  localparam int DW = 8;
  localparam int VL = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stripes_weight_serializer_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) bus ();

  stripes_weight_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int     act [VL];
  int     nxt_act [VL];
  longint prev_cur = 0;
  longint nxt_prev = 0;
  longint cyc = 0;

  typedef struct {
    longint due;
    longint val;
  } exp_t;
  exp_t sb[$];

  longint psum_q = 0;
  longint acc = 0;
  longint term_n = 0;
  longint prev_n = 0;
  logic   en_n = 1'b0;
  logic   load_n = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [VL-1:0] wb_vec();
    logic [VL-1:0] r;
    for (int j = 0; j < VL; j++) r[j] = bus.mac_w_bit[j];
    return r;
  endfunction

  function automatic logic [VL-1:0] bits(input logic [DW-1:0] w [VL], input int c);
    logic [VL-1:0] r;
    for (int j = 0; j < VL; j++) r[j] = w[j][c];
    return r;
  endfunction

  function automatic logic [10:0] obs();
    logic [VL-1:0] b;
    b = wb_vec();
    return {bus.w_ready, bus.mac_en, bus.mac_load_accum, bus.mac_is_msb, bus.result_valid,
            bus.busy, bus.mac_column_idx, |b, &b};
  endfunction

  // Downstream MAC: each issued column contributes +/- (sum of selected acts) * 2^col.
  function automatic longint col_term();
    longint s;
    s = 0;
    for (int j = 0; j < VL; j++) if (bus.mac_w_bit[j]) s += act[j];
    s = s * (longint'(1) << bus.mac_column_idx);
    return bus.mac_is_msb ? -s : s;
  endfunction

  function automatic int ncols();
    logic [DW-1:0] m;
    int n;
    m = '0;
    for (int j = 0; j < VL; j++) m = m | bus.w_data[j];
`ifdef STRIPES_SER_SKIP_ZERO_EN
    n = $countones(m);
    if (n == 0) n = 1;
`else
    n = DW;
`endif
    return n;
  endfunction

  function automatic longint dot_ref();
    longint d;
    d = nxt_prev;
    for (int j = 0; j < VL; j++) d += longint'($signed(bus.w_data[j])) * nxt_act[j];
    return d;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
    end else begin
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          fail("spurious_result_valid");
        end else begin
          e = sb.pop_front();
          check("result_cycle", cyc, e.due);
          check("result_value", acc, e.val);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        fail("result_valid_missing");
        void'(sb.pop_front());
      end
      if (bus.w_valid && bus.w_ready) sb.push_back('{cyc + ncols() + 2, dot_ref()});
    end
    en_n   = bus.mac_en;
    load_n = bus.mac_load_accum;
    term_n = col_term();
    prev_n = prev_cur;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      psum_q <= 0;
      acc    <= 0;
    end else if (en_n) begin
      psum_q <= term_n;
      acc    <= load_n ? prev_n + psum_q : acc + psum_q;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w [VL]);
    logic r;
    r = 1'b0;
    for (int j = 0; j < VL; j++) bus.w_data[j] = w[j];
    bus.w_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      #1;
      r = bus.w_ready;
      tick();
      if (r) break;
    end
    if (!r) fail("send_timeout");
    for (int j = 0; j < VL; j++) act[j] = nxt_act[j];
    prev_cur = nxt_prev;
    bus.w_valid = 1'b0;
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] wdata;
    logic [10:0]   exp;
  } row_t;
  row_t tbl[12];

  logic [DW-1:0] wa [VL];
  logic [DW-1:0] wb [VL];
  logic [DW-1:0] wr [VL];
  logic          seen;

  initial begin
    bus.w_valid = 1'b0;
    for (int j = 0; j < VL; j++) begin
      bus.w_data[j] = '0;
      act[j]        = 3;
      nxt_act[j]    = 3;
    end

    for (int k = 0; k < 12; k++) begin
      logic wbk;
      wbk          = (k == 1) || (k == 8);
      tbl[k].valid = (k == 0);
      tbl[k].wdata = 8'h81;
      tbl[k].exp   = {(k == 0) || (k >= 8), (k >= 1) && (k <= 9), k == 2, k == 1, k == 10,
                      (k >= 1) && (k <= 9), ((k >= 1) && (k <= 8)) ? 3'(8 - k) : 3'd0, wbk, wbk};
    end

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", obs(), 0);
    tick();
    reset = 1'b1;

`ifdef STRIPES_SER_SKIP_ZERO_EN
    for (int j = 0; j < VL; j++) wa[j] = 8'h04;
    send(wa);
    @(negedge clk);
    check("skip_only_col2", {bus.mac_column_idx, bus.mac_is_msb, bus.mac_en}, {3'd2, 1'b0, 1'b1});
    tick();
    @(negedge clk);
    check("skip_load_next", bus.mac_load_accum, 1);
    tick();
    @(negedge clk);
    check("skip_rv_after2", bus.result_valid, 1);
    tick();
    for (int j = 0; j < VL; j++) wa[j] = 8'h00;
    send(wa);
    @(negedge clk);
    check("skip_zero_col0", {bus.mac_column_idx, bus.mac_is_msb, bus.mac_en}, {3'd0, 1'b0, 1'b1});
    tick();
    @(negedge clk);
    check("skip_zero_load", bus.mac_load_accum, 1);
    repeat (4) tick();
`else
    for (int k = 0; k < 12; k++) begin
      bus.w_valid = tbl[k].valid;
      for (int j = 0; j < VL; j++) bus.w_data[j] = tbl[k].wdata;
      @(negedge clk);
      check($sformatf("single_row%0d", k), obs(), tbl[k].exp);
      tick();
    end
    bus.w_valid = 1'b0;

    for (int j = 0; j < VL; j++) begin
      wa[j] = DW'($urandom);
      wb[j] = DW'($urandom);
    end
    for (int j = 0; j < VL; j++) bus.w_data[j] = wa[j];
    bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    repeat (2) tick();
    bus.w_valid = 1'b1;
    for (int j = 0; j < VL; j++) bus.w_data[j] = wb[j];
    @(negedge clk);
    check("busy_ready_c3", bus.w_ready, 0);
    check("busy_bits_c3", wb_vec(), bits(wa, 5));
    repeat (5) tick();
    @(negedge clk);
    check("b2b_ready_c8", bus.w_ready, 1);
    check("b2b_bits_c8", wb_vec(), bits(wa, 0));
    tick();
    bus.w_valid = 1'b0;
    @(negedge clk);
    check("b2b_next_c1", {bus.mac_column_idx, bus.mac_is_msb, bus.mac_en}, {3'd7, 1'b1, 1'b1});
    check("b2b_bits_c1", wb_vec(), bits(wb, 7));
    tick();
    @(negedge clk);
    check("b2b_load_with_rv", {bus.mac_load_accum, bus.result_valid}, 2'b11);
    repeat (8) tick();
    @(negedge clk);
    check("b2b_second_rv", bus.result_valid, 1);
    repeat (2) tick();
`endif

    for (int j = 0; j < VL; j++) wa[j] = 8'h81;
    send(wa);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midvec_reset_outputs", obs(), 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    send(wa);
    @(negedge clk);
    check("post_reset_c1", {bus.mac_column_idx, bus.mac_is_msb, bus.mac_en, bus.busy},
          {3'd7, 1'b1, 1'b1, 1'b1});
    check("post_reset_bits", wb_vec(), {VL{1'b1}});
    repeat (12) tick();

    for (int j = 0; j < VL; j++) wa[j] = 8'hFF;
    nxt_prev = 0;
    send(wa);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        seen = 1'b1;
        check("mac_all_minus1", acc, -48);
      end else begin
        tick();
      end
    end
    if (!seen) fail("mac_all_minus1_timeout");
    repeat (3) tick();

    for (int v = 0; v < 40; v++) begin
      logic [DW-1:0] m;
      case ($urandom_range(0, 3))
        0:       m = 8'hFF;
        1:       m = 8'h0F;
        2:       m = 8'h30;
        default: m = 8'h00;
      endcase
      for (int j = 0; j < VL; j++) begin
        wr[j]      = DW'($urandom) & m;
        nxt_act[j] = int'($urandom_range(0, 15));
      end
      nxt_prev = longint'($urandom_range(0, 2000)) - 1000;
      send(wr);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (15) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
